// File: rtl/player_motion_pkg.sv
// Shared maze definitions: travel directions, default maze geometry, wall bit indexing.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package player_motion_pkg;

    // Travel direction encoding, also the {button_1, button_2} request code.
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    // Default maze geometry.
    localparam int COLS_DEF      = 10;
    localparam int ROWS_DEF      = 15;
    localparam int CELL_LOG2_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_MOVE  = 2'd2
    } motion_state_t;

    // Horizontal wall line r (0 = top), segment c. Line 0 sits at the MSB end.
    function automatic int h_idx(input int r, input int c, input int cols, input int rows);
        return (rows + 1) * cols - 1 - (r * cols + c);
    endfunction

    // Vertical wall in cell row r, line c (0 = left). Row 0 / line 0 sits at the MSB end.
    function automatic int v_idx(input int r, input int c, input int cols, input int rows);
        return rows * (cols + 1) - 1 - (r * (cols + 1) + c);
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Bundle of player motion controls: raw buttons, wall maps, advance request and position result.
// Latency: n/a (wires only).
// Backpressure: advance is dropped by the slave while busy is high; it is never queued.
interface player_motion_if #(
    parameter int COLS = player_motion_pkg::COLS_DEF,
    parameter int ROWS = player_motion_pkg::ROWS_DEF
) ();
    logic                         button_1;   // raw button, direction MSB
    logic                         button_2;   // raw button, direction LSB
    logic [(ROWS+1)*COLS-1:0]     h_walls;    // horizontal wall lines
    logic [ROWS*(COLS+1)-1:0]     v_walls;    // vertical wall lines
    logic                         advance;    // one-cycle step request
    logic                         busy;       // step in progress
    logic                         done;       // one-cycle result strobe
    logic [8:0]                   pos_x;      // pixel x, {cell, sub-cell}
    logic [8:0]                   pos_y;      // pixel y, {cell, sub-cell}
    logic [1:0]                   direction;  // latched travel direction
    logic                         blocked;    // last step hit a wall or border

    modport master (
        output button_1, button_2, h_walls, v_walls, advance,
        input  busy, done, pos_x, pos_y, direction, blocked
    );

    modport slave (
        input  button_1, button_2, h_walls, v_walls, advance,
        output busy, done, pos_x, pos_y, direction, blocked
    );
endinterface

// File: rtl/player_motion_debouncer.sv
// Button conditioner: 2-FF synchroniser followed by a stable-count debouncer.
// Latency: 2 sync cycles + DEB_CYC consecutive matching samples before deb follows btn.
// Backpressure: none; free-running on every clk.
// Ports: clk, rst (sync, active-low), btn (raw async input), deb (debounced level).
module button_debouncer #(
    parameter int DEB_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic deb
);
    localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            // Count samples that disagree with the accepted level; any agreeing sample restarts.
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/player_motion.sv
// Player movement controller: debounced direction, wall/border check, one STEP per advance.
// Latency: advance sampled at edge N -> done and new position registered at edge N+2.
// Backpressure: advance while busy is ignored (not queued); busy covers CHECK and MOVE.
// Ports: clk, rst (sync, active-low), mif (slave side of player_motion_if).
module player_motion
    import player_motion_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int CELL_LOG2 = CELL_LOG2_DEF,
    parameter int STEP      = 1,
    parameter int DEB_CYC   = 50000,
    parameter int START_X   = 0,
    parameter int START_Y   = 0
) (
    input  logic            clk,
    input  logic            rst,
    player_motion_if.slave  mif
);
    localparam int H_BITS  = (ROWS + 1) * COLS;
    localparam int V_BITS  = ROWS * (COLS + 1);
    localparam int H_SEL_W = $clog2(H_BITS);
    localparam int V_SEL_W = $clog2(V_BITS);
    localparam logic [8:0] START_PX = 9'(START_X * (2 ** CELL_LOG2));
    localparam logic [8:0] START_PY = 9'(START_Y * (2 ** CELL_LOG2));

    motion_state_t state, state_nxt;

    logic       deb_b1, deb_b2;
    logic [1:0] req_dir;
    logic [8:0] pos_x_r, pos_y_r;
    logic [1:0] dir_r;
    logic       wall_r, blocked_r, done_r;

    logic [8-CELL_LOG2:0] cx, cy;
    int                   cx_i, cy_i;
    logic                 aligned;
    logic                 border;
    logic                 edge_wall;
    logic [H_SEL_W-1:0]   h_sel;
    logic [V_SEL_W-1:0]   v_sel;

    button_debouncer #(.DEB_CYC(DEB_CYC)) u_deb_b1 (.clk(clk), .rst(rst), .btn(mif.button_1), .deb(deb_b1));
    button_debouncer #(.DEB_CYC(DEB_CYC)) u_deb_b2 (.clk(clk), .rst(rst), .btn(mif.button_2), .deb(deb_b2));

    assign req_dir = {deb_b1, deb_b2};
    assign cx      = pos_x_r[8:CELL_LOG2];
    assign cy      = pos_y_r[8:CELL_LOG2];
    assign aligned = (pos_x_r[CELL_LOG2-1:0] == '0) && (pos_y_r[CELL_LOG2-1:0] == '0);

    // Edge of the current cell facing the requested direction, plus the maze-border clamp.
    always_comb begin
        cx_i      = int'(cx);
        cy_i      = int'(cy);
        h_sel     = '0;
        v_sel     = '0;
        border    = 1'b0;
        edge_wall = 1'b0;
        case (req_dir)
            DIR_RIGHT: begin
                border    = (cx_i == COLS - 1);
                v_sel     = V_SEL_W'(v_idx(cy_i, cx_i + 1, COLS, ROWS));
                edge_wall = mif.v_walls[v_sel];
            end
            DIR_DOWN: begin
                border    = (cy_i == ROWS - 1);
                h_sel     = H_SEL_W'(h_idx(cy_i + 1, cx_i, COLS, ROWS));
                edge_wall = mif.h_walls[h_sel];
            end
            DIR_LEFT: begin
                border    = (cx_i == 0);
                v_sel     = V_SEL_W'(v_idx(cy_i, cx_i, COLS, ROWS));
                edge_wall = mif.v_walls[v_sel];
            end
            default: begin
                border    = (cy_i == 0);
                h_sel     = H_SEL_W'(h_idx(cy_i, cx_i, COLS, ROWS));
                edge_wall = mif.h_walls[h_sel];
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (mif.advance) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_MOVE;
            ST_MOVE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pos_x_r   <= START_PX;
            pos_y_r   <= START_PY;
            dir_r     <= DIR_RIGHT;
            wall_r    <= 1'b0;
            blocked_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= (state == ST_MOVE);
            if (state == ST_CHECK) begin
                // Turning is only possible on a cell boundary; mid-cell the path was already cleared.
                if (aligned) begin
                    dir_r  <= req_dir;
                    wall_r <= border | edge_wall;
                end else begin
                    wall_r <= 1'b0;
                end
            end
            if (state == ST_MOVE) begin
                blocked_r <= wall_r;
                if (!wall_r) begin
                    case (dir_r)
                        DIR_RIGHT: pos_x_r <= pos_x_r + 9'(STEP);
                        DIR_DOWN:  pos_y_r <= pos_y_r + 9'(STEP);
                        DIR_LEFT:  pos_x_r <= pos_x_r - 9'(STEP);
                        default:   pos_y_r <= pos_y_r - 9'(STEP);
                    endcase
                end
            end
        end
    end

    assign mif.busy      = (state != ST_IDLE);
    assign mif.done      = done_r;
    assign mif.pos_x     = pos_x_r;
    assign mif.pos_y     = pos_y_r;
    assign mif.direction = dir_r;
    assign mif.blocked   = blocked_r;
endmodule
